booth_mul_32: RTL and testbench
===============================

BOOTH_MUL_32 -- requirements
Module: booth_mul_32

Interface
REQ-001 clock  input  1  rising-edge system clock; sole clock of the block.
REQ-002 clear  input  1  reset, synchronous, active-high.
REQ-003 start  input  1  request to begin a multiply; sampled only in IDLE.
REQ-004 mA  input  32  multiplicand, two's complement; captured on the accepted start edge.
REQ-005 mB  input  32  multiplier, two's complement; captured on the accepted start edge.
REQ-006 busy  output  1  high while in RUN.
REQ-007 done  output  1  one-cycle pulse when the product becomes valid.
REQ-008 product_hi  output  32  upper word of the 64-bit signed product, feeding ZHI.
REQ-009 product_lo  output  32  lower word of the 64-bit signed product, feeding ZLO.
REQ-010 ovf  output  1  present only with MUL_OVF_FLAG_EN; product not representable in 32 bits.

Function
REQ-011 Algorithm SHALL be radix-2 Booth: 33-bit accumulator A, 32-bit Q (=mB), 1-bit q_1, 33-bit sign-extended M (=mA).
REQ-012 Each RUN cycle SHALL do exactly one step.
- (Q0,q_1)=01: A+M.
- (Q0,q_1)=10: A-M, i.e. A + ~M + 1 via carry-in.
- 00 or 11: no add.
- Then arithmetic right shift of {A,Q,q_1} by one.
REQ-013 FSM states SHALL be IDLE, RUN, DONE.
- IDLE->RUN on start=1.
- RUN->DONE after 32 steps; a 6-bit step counter counts 0..31.
- DONE->IDLE unconditionally after one cycle.
REQ-014 Accepted start at edge k SHALL load A=0, Q=mB, q_1=0, M=mA, counter=0 and raise busy from edge k.
REQ-015 The 32nd step SHALL complete at edge k+32; done=1 and product valid from edge k+33 (latency 33 cycles), done low at edge k+34.
REQ-016 product_hi/product_lo SHALL equal {A[31:0],Q} as of the last step, held stable until the next accepted start.
REQ-017 start while busy or done is high SHALL be ignored, with no effect on the operation in progress.
REQ-018 start held high continuously SHALL launch a new multiply on the first IDLE cycle after DONE.
REQ-019 Input changes on mA/mB after the accepted start SHALL not affect the result.
REQ-020 The result SHALL be exact for all operand pairs, including mA=mB=0x80000000; the 33-bit accumulator prevents overflow.

Reset
REQ-021 clear=1 at a rising edge SHALL force IDLE, counter=0, busy=0, done=0, product_hi=product_lo=0, ovf=0, A=Q=M=q_1=0.
REQ-022 clear SHALL take priority over start and SHALL abort an operation in any state; no done pulse follows an abort.

Configuration
REQ-023 Macro MUL_OVF_FLAG_EN defined: port ovf SHALL exist and be registered with product.
- ovf=1 iff product_hi != {32{product_lo[31]}}.
- ovf is held with the product and cleared on start or clear.
REQ-024 Macro MUL_OVF_FLAG_EN undefined: port ovf and its logic SHALL be absent, with all other behaviour identical.

Structure
REQ-025 A shared package SHALL hold the FSM state encoding (IDLE, RUN, DONE), the MUL_WIDTH=32 and MUL_STEPS=32 constants, and the Booth op encoding (NOP, ADD, SUB).
REQ-026 One combinational sub-module, booth_step, SHALL perform the 33-bit add/subtract plus arithmetic shift for one iteration; booth_mul_32 holds the FSM, counter and registers.

Verification
REQ-027 The bench SHALL cover these directed scenarios:
- mA=3, mB=5, start pulse -> done at exactly 33 cycles; product_hi=0x00000000, product_lo=0x0000000F.
- mA=0xFFFFFFFF (-1), mB=0xFFFFFFFF -> product=0x0000000000000001; ovf=0 when enabled.
- mA=mB=0x80000000 -> product_hi=0x40000000, product_lo=0x00000000; ovf=1 when enabled.
- mA=-7, mB=6; second start mid-RUN with different operands -> result remains 0xFFFFFFFF_FFFFFFD6; single done pulse.
- clear asserted at step 10 -> next edge: busy=0, product=0, no done; then mA=0, mB=0x12345678 -> product 0.
- start held high for 80 cycles with mA=2, mB=-4 -> back-to-back results 0xFFFFFFFF_FFFFFFF8; done pulses 34 cycles apart.

Source files
------------

// File: rtl/booth_mul_32_pkg.sv
// Shared definitions for the radix-2 Booth 32x32 signed multiplier:
// operand width, step count, FSM state encoding and Booth op encoding.
package booth_mul_32_pkg;

  localparam int unsigned MUL_WIDTH = 32;
  localparam int unsigned MUL_STEPS = 32;

  // FSM state encoding (kept as plain constants for legacy compatibility)
  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  // Booth recoding of the (Q0, q_1) pair
  localparam logic [1:0] OpNop = 2'd0;
  localparam logic [1:0] OpAdd = 2'd1;
  localparam logic [1:0] OpSub = 2'd2;

  function automatic logic [1:0] boothOp(input logic q0, input logic qm1);
    logic [1:0] op;
    case ({q0, qm1})
      2'b01:   op = OpAdd;
      2'b10:   op = OpSub;
      default: op = OpNop;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/booth_mul_32_step.sv
// booth_step: one combinational radix-2 Booth iteration. Adds or subtracts the
// 33-bit multiplicand according to (Q0, q_1), then arithmetic-shifts {A, Q, q_1}
// right by one.
module booth_step
  import booth_mul_32_pkg::*;
(
  input  logic [MUL_WIDTH:0]   acc,
  input  logic [MUL_WIDTH-1:0] q,
  input  logic                 q1,
  input  logic [MUL_WIDTH:0]   m,
  output logic [MUL_WIDTH:0]   accNext,
  output logic [MUL_WIDTH-1:0] qNext,
  output logic                 q1Next
);

  logic [MUL_WIDTH:0] addend;
  logic [MUL_WIDTH:0] sum;
  logic               carryIn;

  // Add/subtract selected by the Booth pair, then shift the whole chain right
  always_comb begin
    addend  = '0;
    carryIn = 1'b0;
    case (boothOp(q[0], q1))
      OpAdd: addend = m;
      OpSub: begin
        // A - M as A + ~M + 1
        addend  = ~m;
        carryIn = 1'b1;
      end
      default: addend = '0;
    endcase
    sum     = acc + addend + {{MUL_WIDTH{1'b0}}, carryIn};
    accNext = {sum[MUL_WIDTH], sum[MUL_WIDTH:1]};
    qNext   = {sum[0], q[MUL_WIDTH-1:1]};
    q1Next  = q[0];
  end

endmodule

// File: rtl/booth_mul_32.sv
// booth_mul_32: sequential 32x32 signed multiplier, one radix-2 Booth step per
// cycle. Holds the IDLE/RUN/DONE FSM, step counter and datapath registers; the
// arithmetic lives in booth_step.
// Optional feature: define MUL_OVF_FLAG_EN to add the registered ovf output
// (product not representable in 32 bits).
module booth_mul_32
  import booth_mul_32_pkg::*;
(
  input  logic                 clock,
  input  logic                 clear,
  input  logic                 start,
  input  logic [MUL_WIDTH-1:0] mA,
  input  logic [MUL_WIDTH-1:0] mB,
  output logic                 busy,
  output logic                 done,
  output logic [MUL_WIDTH-1:0] product_hi,
  output logic [MUL_WIDTH-1:0] product_lo
`ifdef MUL_OVF_FLAG_EN
  ,
  output logic                 ovf
`endif
);

  localparam logic [5:0] LastStep = 6'(MUL_STEPS - 1);

  logic [1:0]           stateQ;
  logic [5:0]           cntQ;
  logic [MUL_WIDTH:0]   accQ;
  logic [MUL_WIDTH-1:0] qQ;
  logic                 q1Q;
  logic [MUL_WIDTH:0]   mQ;
  logic [MUL_WIDTH-1:0] hiQ;
  logic [MUL_WIDTH-1:0] loQ;
  logic                 doneQ;

  logic [MUL_WIDTH:0]   accNext;
  logic [MUL_WIDTH-1:0] qNext;
  logic                 q1Next;

  booth_step uStep (
    .acc     (accQ),
    .q       (qQ),
    .q1      (q1Q),
    .m       (mQ),
    .accNext (accNext),
    .qNext   (qNext),
    .q1Next  (q1Next)
  );

`ifdef MUL_OVF_FLAG_EN
  logic ovfQ;

  // Overflow flag: captured alongside the product, cleared when a new run starts
  always_ff @(posedge clock) begin
    if (clear) begin
      ovfQ <= 1'b0;
    end else if (stateQ == StIdle && start) begin
      ovfQ <= 1'b0;
    end else if (stateQ == StDone) begin
      ovfQ <= (accQ[MUL_WIDTH-1:0] != {MUL_WIDTH{qQ[MUL_WIDTH-1]}});
    end
  end

  assign ovf = ovfQ;
`endif

  // FSM, step counter and datapath registers; clear overrides everything
  always_ff @(posedge clock) begin
    if (clear) begin
      stateQ <= StIdle;
      cntQ   <= '0;
      accQ   <= '0;
      qQ     <= '0;
      q1Q    <= 1'b0;
      mQ     <= '0;
      hiQ    <= '0;
      loQ    <= '0;
      doneQ  <= 1'b0;
    end else begin
      doneQ <= 1'b0;
      case (stateQ)
        StIdle: begin
          if (start) begin
            accQ   <= '0;
            qQ     <= mB;
            q1Q    <= 1'b0;
            mQ     <= {mA[MUL_WIDTH-1], mA};
            cntQ   <= '0;
            stateQ <= StRun;
          end
        end
        StRun: begin
          accQ <= accNext;
          qQ   <= qNext;
          q1Q  <= q1Next;
          if (cntQ == LastStep) begin
            cntQ   <= '0;
            stateQ <= StDone;
          end else begin
            cntQ <= cntQ + 6'd1;
          end
        end
        StDone: begin
          // Publish the product one cycle after the final step
          hiQ    <= accQ[MUL_WIDTH-1:0];
          loQ    <= qQ;
          doneQ  <= 1'b1;
          stateQ <= StIdle;
        end
        default: stateQ <= StIdle;
      endcase
    end
  end

  assign busy       = (stateQ == StRun);
  assign done       = doneQ;
  assign product_hi = hiQ;
  assign product_lo = loQ;

endmodule

// File: tb/tb_booth_mul_32.sv
// Self-checking bench for booth_mul_32: expected products are queued when a
// start is driven and compared when done pulses.
module tb_booth_mul_32;

  logic        clock = 1'b0;
  logic        clear;
  logic        start;
  logic [31:0] mA;
  logic [31:0] mB;
  logic        busy;
  logic        done;
  logic [31:0] product_hi;
  logic [31:0] product_lo;
`ifdef MUL_OVF_FLAG_EN
  logic        ovf;
`endif

  int nChecks = 0;
  int nErrors = 0;
  int cycCnt  = 0;

  logic [63:0] sb[$];
  int          doneTimes[$];

  booth_mul_32 dut (
    .clock      (clock),
    .clear      (clear),
    .start      (start),
    .mA         (mA),
    .mB         (mB),
    .busy       (busy),
    .done       (done),
    .product_hi (product_hi),
    .product_lo (product_lo)
`ifdef MUL_OVF_FLAG_EN
    ,
    .ovf        (ovf)
`endif
  );

  always #5 clock = ~clock;

  always @(posedge clock) cycCnt <= cycCnt + 1;

  task automatic checkEq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErrors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] refMul(input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa;
    logic signed [63:0] sbv;
    sa  = $signed({{32{a[31]}}, a});
    sbv = $signed({{32{b[31]}}, b});
    return sa * sbv;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Counts edges after the accepting edge until done is seen
  task automatic waitDone(output int lat);
    lat = 0;
    while (!done && lat < 60) begin
      tick();
      lat++;
    end
    if (!done) checkEq("doneTimeout", 64'(done), 64'd1);
  endtask

  task automatic runOp(input logic [31:0] a, input logic [31:0] b, input logic [63:0] exp);
    int lat;
    sb.push_back(exp);
    mA    = a;
    mB    = b;
    start = 1'b1;
    tick();
    start = 1'b0;
    mA    = $urandom;
    mB    = $urandom;
    waitDone(lat);
    tick();
  endtask

  // Scoreboard: compare every done pulse against the oldest queued expectation
  always @(negedge clock) begin
    if (done) begin
      doneTimes.push_back(cycCnt);
      if (sb.size() == 0) begin
        checkEq("spuriousDone", 64'(done), 64'd0);
      end else begin
        logic [63:0] e;
        e = sb.pop_front();
        checkEq("product", {product_hi, product_lo}, e);
`ifdef MUL_OVF_FLAG_EN
        checkEq("ovf", 64'(ovf), 64'(e[63:32] != {32{e[31]}}));
`endif
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat;
    int d0;
    logic [31:0] ra;
    logic [31:0] rb;

    clear = 1'b1;
    start = 1'b0;
    mA    = '0;
    mB    = '0;
    tick();
    tick();
    checkEq("rstBusy", 64'(busy), 64'd0);
    checkEq("rstDone", 64'(done), 64'd0);
    checkEq("rstProduct", {product_hi, product_lo}, 64'd0);
`ifdef MUL_OVF_FLAG_EN
    checkEq("rstOvf", 64'(ovf), 64'd0);
`endif
    clear = 1'b0;
    tick();

    // 3 * 5: exact latency and one-cycle done pulse
    sb.push_back(64'h0000_0000_0000_000F);
    mA    = 32'd3;
    mB    = 32'd5;
    start = 1'b1;
    tick();
    checkEq("busyAtAccept", 64'(busy), 64'd1);
    start = 1'b0;
    mA    = $urandom;
    mB    = $urandom;
    waitDone(lat);
    checkEq("latency", 64'(lat), 64'd33);
    tick();
    checkEq("doneWidth", 64'(done), 64'd0);
    checkEq("busyAfterDone", 64'(busy), 64'd0);
    checkEq("productHeld", {product_hi, product_lo}, 64'h0000_0000_0000_000F);

    runOp(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001);
    runOp(32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);

    // -7 * 6 with a second start mid-RUN that must be ignored
    sb.push_back(64'hFFFF_FFFF_FFFF_FFD6);
    mA    = -32'sd7;
    mB    = 32'd6;
    start = 1'b1;
    tick();
`ifdef MUL_OVF_FLAG_EN
    checkEq("ovfClearedOnStart", 64'(ovf), 64'd0);
`endif
    start = 1'b0;
    repeat (5) tick();
    mA    = 32'd100;
    mB    = 32'd200;
    start = 1'b1;
    tick();
    start = 1'b0;
    d0 = doneTimes.size();
    waitDone(lat);
    checkEq("midRunLatency", 64'(lat), 64'd27);
    repeat (40) tick();
    checkEq("singleDone", 64'(doneTimes.size() - d0), 64'd1);
    checkEq("idleAfterIgnore", 64'(busy), 64'd0);

    // Abort with clear after ten steps
    mA    = 32'h0BAD_F00D;
    mB    = 32'h1357_9BDF;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (10) tick();
    checkEq("busyBeforeClear", 64'(busy), 64'd1);
    clear = 1'b1;
    d0 = doneTimes.size();
    tick();
    clear = 1'b0;
    checkEq("clearBusy", 64'(busy), 64'd0);
    checkEq("clearDone", 64'(done), 64'd0);
    checkEq("clearProduct", {product_hi, product_lo}, 64'd0);
`ifdef MUL_OVF_FLAG_EN
    checkEq("clearOvf", 64'(ovf), 64'd0);
`endif
    repeat (45) tick();
    checkEq("noDoneAfterAbort", 64'(doneTimes.size() - d0), 64'd0);
    runOp(32'h0000_0000, 32'h1234_5678, 64'd0);

    // start held high for 80 cycles: three back-to-back launches
    d0 = doneTimes.size();
    repeat (3) sb.push_back(64'hFFFF_FFFF_FFFF_FFF8);
    mA    = 32'd2;
    mB    = -32'sd4;
    start = 1'b1;
    repeat (80) tick();
    start = 1'b0;
    lat = 0;
    while (sb.size() != 0 && lat < 80) begin
      tick();
      lat++;
    end
    tick();
    checkEq("heldDoneCount", 64'(doneTimes.size() - d0), 64'd3);
    if (doneTimes.size() >= d0 + 3) begin
      checkEq("heldSpacing1", 64'(doneTimes[d0+1] - doneTimes[d0]), 64'd34);
      checkEq("heldSpacing2", 64'(doneTimes[d0+2] - doneTimes[d0+1]), 64'd34);
    end

    // Random operands against the reference product
    repeat (6) begin
      ra = $urandom;
      rb = $urandom;
      runOp(ra, rb, refMul(ra, rb));
    end
    runOp(32'h7FFF_FFFF, 32'h8000_0000, refMul(32'h7FFF_FFFF, 32'h8000_0000));

    repeat (3) tick();
    checkEq("scoreboardEmpty", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule
